// File: rtl/spi_arbiter.sv
// Two-requester round-robin arbiter in front of a byte-oriented SPI master.
// The granted requester streams LEN bytes; every byte is a start/busy/capture handshake.
module spi_arbiter #(
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [LEN_W-1:0] LEN0,
    input  logic [LEN_W-1:0] LEN1,
    input  logic [7:0]       TXD0,
    input  logic [7:0]       TXD1,
    output logic             TXRD0,
    output logic             TXRD1,
    output logic [7:0]       RXD0,
    output logic [7:0]       RXD1,
    output logic             RXVLD0,
    output logic             RXVLD1,
    output logic             DONE0,
    output logic             DONE1,
    output logic             ERR0,
    output logic             ERR1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             SPI_START,
    output logic [7:0]       SPI_DOUT,
    input  logic             SPI_BUSY,
    input  logic [7:0]       SPI_DIN
);

    localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StStartHi,
        StWaitBusy,
        StWaitDone,
        StCapture
    } state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [TmrW-1:0]  tmr_q, tmr_d;
    logic [7:0]       dout_q, dout_d;
    logic [7:0]       rxd0_q, rxd0_d;
    logic [7:0]       rxd1_q, rxd1_d;
    logic [1:0]       rxvld_q, rxvld_d;
    logic [1:0]       done_q, done_d;
    logic [1:0]       err_q, err_d;

    logic             pick;
    logic [LEN_W-1:0] len_sel;
    logic [7:0]       txd_sel;
    logic [1:0]       own_oh;
    logic             active;

    assign own_oh  = owner_q ? 2'b10 : 2'b01;
    assign txd_sel = owner_q ? TXD1 : TXD0;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        rem_d   = rem_q;
        tmr_d   = tmr_q;
        dout_d  = dout_q;
        rxd0_d  = rxd0_q;
        rxd1_d  = rxd1_q;
        rxvld_d = 2'b00;
        done_d  = 2'b00;
        err_d   = 2'b00;
        pick    = 1'b0;
        len_sel = LEN0;

        unique case (state_q)
            StIdle: begin
                if (REQ0 || REQ1) begin
                    // On contention the requester that did not finish last wins.
                    pick    = (REQ0 && REQ1) ? ~last_q : REQ1;
                    len_sel = pick ? LEN1 : LEN0;
                    owner_d = pick;
                    if (len_sel == '0) begin
                        done_d = pick ? 2'b10 : 2'b01;
                        last_d = pick;
                    end else begin
                        rem_d   = len_sel;
                        state_d = StStartHi;
                    end
                end
            end
            StStartHi: begin
                dout_d  = txd_sel;
                tmr_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (SPI_BUSY) begin
                    state_d = StWaitDone;
                end else if (tmr_q == TmrW'(TIMEOUT - 1)) begin
                    err_d   = own_oh;
                    last_d  = owner_q;
                    state_d = StIdle;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            StWaitDone: begin
                if (!SPI_BUSY) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                rxvld_d = own_oh;
                if (owner_q) begin
                    rxd1_d = SPI_DIN;
                end else begin
                    rxd0_d = SPI_DIN;
                end
                if (rem_q != '0) begin
                    rem_d = rem_q - LEN_W'(1);
                end
                if (rem_q > LEN_W'(1)) begin
                    state_d = StStartHi;
                end else begin
                    done_d  = own_oh;
                    last_d  = owner_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            rem_q   <= '0;
            tmr_q   <= '0;
            dout_q  <= '0;
            rxd0_q  <= '0;
            rxd1_q  <= '0;
            rxvld_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rem_q   <= rem_d;
            tmr_q   <= tmr_d;
            dout_q  <= dout_d;
            rxd0_q  <= rxd0_d;
            rxd1_q  <= rxd1_d;
            rxvld_q <= rxvld_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Strobes decode from state so reset clears them without waiting for a clock.
    assign active    = (state_q != StIdle);
    assign GNT0      = active && !owner_q;
    assign GNT1      = active && owner_q;
    assign SPI_START = (state_q == StStartHi);
    assign TXRD0     = SPI_START && !owner_q;
    assign TXRD1     = SPI_START && owner_q;
    // Live byte during the start cycle, then the captured copy until capture.
    assign SPI_DOUT  = SPI_START ? txd_sel : dout_q;
    assign RXD0      = rxd0_q;
    assign RXD1      = rxd1_q;
    assign RXVLD0    = rxvld_q[0];
    assign RXVLD1    = rxvld_q[1];
    assign DONE0     = done_q[0];
    assign DONE1     = done_q[1];
    assign ERR0      = err_q[0];
    assign ERR1      = err_q[1];

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: a simple SPI slave model, pulse monitors and
// hand-computed expectations for single, multi-byte, contention, timeout and reset cases.
module tb_spi_arbiter;

    localparam int unsigned LEN_W   = 4;
    localparam int unsigned TIMEOUT = 8;

    logic             CLK = 1'b0;
    logic             RST;
    logic             REQ0, REQ1;
    logic [LEN_W-1:0] LEN0, LEN1;
    logic [7:0]       TXD0, TXD1;
    logic             TXRD0, TXRD1;
    logic [7:0]       RXD0, RXD1;
    logic             RXVLD0, RXVLD1;
    logic             DONE0, DONE1;
    logic             ERR0, ERR1;
    logic             GNT0, GNT1;
    logic             SPI_START;
    logic [7:0]       SPI_DOUT;
    logic             SPI_BUSY;
    logic [7:0]       SPI_DIN;

    spi_arbiter #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .LEN0(LEN0), .LEN1(LEN1),
        .TXD0(TXD0), .TXD1(TXD1), .TXRD0(TXRD0), .TXRD1(TXRD1),
        .RXD0(RXD0), .RXD1(RXD1), .RXVLD0(RXVLD0), .RXVLD1(RXVLD1),
        .DONE0(DONE0), .DONE1(DONE1), .ERR0(ERR0), .ERR1(ERR1),
        .GNT0(GNT0), .GNT1(GNT1),
        .SPI_START(SPI_START), .SPI_DOUT(SPI_DOUT),
        .SPI_BUSY(SPI_BUSY), .SPI_DIN(SPI_DIN)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Slave: busy raised in the start cycle, dropped three negedges later with DIN = DOUT ^ xor.
    logic       slave_en = 1'b0;
    logic [7:0] slv_xor  = 8'h00;
    int         slv_cnt  = 0;

    initial begin
        SPI_BUSY = 1'b0;
        SPI_DIN  = 8'h00;
    end

    always @(negedge CLK) begin
        if (RST) begin
            slv_cnt  = 0;
            SPI_BUSY = 1'b0;
        end else if (slv_cnt > 0) begin
            slv_cnt = slv_cnt - 1;
            if (slv_cnt == 0) begin
                SPI_BUSY = 1'b0;
                SPI_DIN  = SPI_DOUT ^ slv_xor;
            end
        end else if (slave_en && SPI_START) begin
            SPI_BUSY = 1'b1;
            slv_cnt  = 3;
        end
    end

    int n_start = 0, n_txrd0 = 0, n_txrd1 = 0, n_rxv0 = 0, n_rxv1 = 0;
    int n_done0 = 0, n_done1 = 0, n_err0 = 0, n_err1 = 0;
    int n_overlap = 0, n_b2b = 0, n_unstable = 0;
    logic       prev_start = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] dout_log[$];
    logic [7:0] rx0_log[$];
    logic [7:0] rx1_log[$];

    always @(negedge CLK) begin
        if (SPI_START) begin
            n_start++;
            if (prev_start) n_b2b++;
            held = SPI_DOUT;
            dout_log.push_back(SPI_DOUT);
        end else if ((GNT0 || GNT1) && SPI_DOUT !== held) begin
            n_unstable++;
        end
        prev_start = SPI_START;
        if (TXRD0) n_txrd0++;
        if (TXRD1) n_txrd1++;
        if (RXVLD0) begin n_rxv0++; rx0_log.push_back(RXD0); end
        if (RXVLD1) begin n_rxv1++; rx1_log.push_back(RXD1); end
        if (DONE0) n_done0++;
        if (DONE1) n_done1++;
        if (ERR0) n_err0++;
        if (ERR1) n_err1++;
        if (GNT0 && GNT1) n_overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic sig(input int k);
        case (k)
            0:       return DONE0;
            1:       return DONE1;
            2:       return ERR0;
            default: return SPI_START;
        endcase
    endfunction

    task automatic wait_ev(input string tag, input int k, input int bound, output int cyc);
        cyc = 0;
        while (sig(k) !== 1'b1 && cyc < bound) begin
            tick();
            cyc++;
        end
        chk({tag, "_seen"}, 32'(sig(k)), 32'd1);
    endtask

    int cyc;
    int b_start, b_txrd0, b_txrd1, b_rxv0, b_rxv1, b_done0, b_done1, b_err0, b_err1;

    task automatic snap();
        b_start = n_start; b_txrd0 = n_txrd0; b_txrd1 = n_txrd1;
        b_rxv0 = n_rxv0; b_rxv1 = n_rxv1; b_done0 = n_done0; b_done1 = n_done1;
        b_err0 = n_err0; b_err1 = n_err1;
    endtask

    initial begin
        RST = 1'b1;
        REQ0 = 1'b0; REQ1 = 1'b0;
        LEN0 = '0; LEN1 = '0;
        TXD0 = 8'h00; TXD1 = 8'h00;
        tick();
        tick();
        chk("rst_gnt", {30'd0, GNT1, GNT0}, 32'd0);
        chk("rst_start", 32'(SPI_START), 32'd0);
        chk("rst_dout", 32'(SPI_DOUT), 32'd0);
        chk("rst_rxd", {16'd0, RXD1, RXD0}, 32'd0);
        chk("rst_pulses", {24'd0, DONE1, DONE0, ERR1, ERR0, RXVLD1, RXVLD0, TXRD1, TXRD0}, 32'd0);
        RST = 1'b0;
        tick();

        // Single byte: A5 out, 3C back.
        slave_en = 1'b1; slv_xor = 8'h99;
        snap();
        TXD0 = 8'hA5; LEN0 = 4'd1; REQ0 = 1'b1;
        tick();
        chk("s1_start", 32'(SPI_START), 32'd1);
        chk("s1_gnt0", 32'(GNT0), 32'd1);
        chk("s1_txrd0", 32'(TXRD0), 32'd1);
        chk("s1_dout", 32'(SPI_DOUT), 32'hA5);
        REQ0 = 1'b0;
        wait_ev("s1_done0", 0, 20, cyc);
        chk("s1_rxd0", 32'(RXD0), 32'h3C);
        chk("s1_rxvld0", 32'(RXVLD0), 32'd1);
        chk("s1_gnt0_low", 32'(GNT0), 32'd0);
        tick();
        chk("s1_nstart", 32'(n_start - b_start), 32'd1);
        chk("s1_ndone0", 32'(n_done0 - b_done0), 32'd1);
        chk("s1_nrxv0", 32'(n_rxv0 - b_rxv0), 32'd1);

        // Three-byte burst on requester 1; REQ1 dropped after the first byte.
        slv_xor = 8'h00;
        snap();
        TXD1 = 8'h01; LEN1 = 4'd3; REQ1 = 1'b1;
        tick();
        for (int b = 1; b <= 3; b++) begin
            if (b > 1) wait_ev("s2_start", 3, 20, cyc);
            chk("s2_dout", 32'(SPI_DOUT), 32'(b));
            chk("s2_txrd1", 32'(TXRD1), 32'd1);
            tick();
            TXD1 = 8'(b + 1);
            if (b == 1) REQ1 = 1'b0;
        end
        wait_ev("s2_done1", 1, 20, cyc);
        tick();
        chk("s2_ntxrd1", 32'(n_txrd1 - b_txrd1), 32'd3);
        chk("s2_ntxrd0", 32'(n_txrd0 - b_txrd0), 32'd0);
        chk("s2_nrxv1", 32'(n_rxv1 - b_rxv1), 32'd3);
        chk("s2_ndone1", 32'(n_done1 - b_done1), 32'd1);
        chk("s2_nstart", 32'(n_start - b_start), 32'd3);
        chk("s2_dlog", {8'd0, dout_log[$-2], dout_log[$-1], dout_log[$]}, 32'h010203);
        chk("s2_rlog", {8'd0, rx1_log[$-2], rx1_log[$-1], rx1_log[$]}, 32'h010203);

        // Contention from reset: 0, then 1, then 0 again.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        TXD0 = 8'h20; TXD1 = 8'h30; LEN0 = 4'd2; LEN1 = 4'd2;
        REQ0 = 1'b1; REQ1 = 1'b1;
        tick();
        chk("s3_first", {30'd0, GNT1, GNT0}, 32'b01);
        wait_ev("s3_done0a", 0, 30, cyc);
        tick();
        chk("s3_second", {30'd0, GNT1, GNT0}, 32'b10);
        wait_ev("s3_done1", 1, 30, cyc);
        tick();
        chk("s3_third", {30'd0, GNT1, GNT0}, 32'b01);
        REQ0 = 1'b0; REQ1 = 1'b0;
        wait_ev("s3_done0b", 0, 30, cyc);
        tick();
        chk("s3_overlap", 32'(n_overlap), 32'd0);
        chk("s3_b2b", 32'(n_b2b), 32'd0);
        chk("s3_unstable", 32'(n_unstable), 32'd0);

        // Timeout: slave never raises busy.
        slave_en = 1'b0;
        snap();
        LEN0 = 4'd1; REQ0 = 1'b1;
        tick();
        REQ0 = 1'b0;
        wait_ev("s4_err0", 2, 40, cyc);
        chk("s4_latency", 32'(cyc), 32'(TIMEOUT + 1));
        chk("s4_gnt", {30'd0, GNT1, GNT0}, 32'd0);
        tick();
        chk("s4_nodone", 32'(n_done0 - b_done0), 32'd0);
        chk("s4_nerr0", 32'(n_err0 - b_err0), 32'd1);

        // Zero-length burst.
        slave_en = 1'b1;
        snap();
        LEN0 = 4'd0; REQ0 = 1'b1;
        tick();
        REQ0 = 1'b0;
        chk("s5_done0", 32'(DONE0), 32'd1);
        chk("s5_gnt0", 32'(GNT0), 32'd0);
        tick();
        chk("s5_nstart", 32'(n_start - b_start), 32'd0);
        chk("s5_ntxrd0", 32'(n_txrd0 - b_txrd0), 32'd0);

        // Reset during WAIT_DONE of byte 2 of 4.
        TXD0 = 8'h11; LEN0 = 4'd4; REQ0 = 1'b1;
        tick();
        tick();
        REQ0 = 1'b0;
        wait_ev("s6_start2", 3, 20, cyc);
        tick();
        tick();
        chk("s6_rxd0_pre", 32'(RXD0), 32'h11);
        snap();
        RST = 1'b1;
        #1;
        chk("s6_gnt", {30'd0, GNT1, GNT0}, 32'd0);
        chk("s6_start", 32'(SPI_START), 32'd0);
        chk("s6_dout", 32'(SPI_DOUT), 32'd0);
        chk("s6_rxd0", 32'(RXD0), 32'd0);
        tick();
        tick();
        RST = 1'b0;
        tick();
        chk("s6_nodone", 32'(n_done0 + n_done1 - b_done0 - b_done1), 32'd0);
        chk("s6_noerr", 32'(n_err0 + n_err1 - b_err0 - b_err1), 32'd0);
        LEN0 = 4'd1; LEN1 = 4'd1; REQ0 = 1'b1; REQ1 = 1'b1;
        tick();
        chk("s6_regrant", {30'd0, GNT1, GNT0}, 32'b01);
        REQ0 = 1'b0; REQ1 = 1'b0;
        wait_ev("s6_done0", 0, 20, cyc);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
